// File: rtl/mi_nios_spi_slave.sv
// SPI slave endpoint (CPOL=0, CPHA=0, MSB first) with an Avalon register window.
// SPI pins are oversampled in the clk domain; single-byte RX/TX holding registers.
module mi_nios_spi_slave #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq
);

  localparam int          CW        = $clog2(DATABITS);
  localparam logic [15:0] CTRL_MASK = 16'h01D8;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  // Synchronizers; the extra top flop on SS_n/SCLK holds the previous sample for edge detection
  logic [SYNC_STAGES:0]   r_ss_sync;
  logic [SYNC_STAGES:0]   r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  state_t                r_state;
  logic [CW-1:0]         r_bitcnt;
  logic [DATABITS-1:0]   r_rx_shift;
  logic [DATABITS-1:0]   r_tx_shift;
  logic [DATABITS-1:0]   r_tx_pend;
  logic                  r_reload_pend;
  logic [DATABITS-1:0]   r_rx_hold;
  logic                  r_miso_oe;

  logic [DATABITS-1:0]   r_tx_hold;
  logic                  r_primed;
  logic                  r_rrdy;
  logic                  r_roe;
  logic                  r_toe;
  logic                  r_und;
  logic [15:0]           r_ctrl;
  logic [15:0]           r_data_to_cpu;
  logic                  r_irq;

  logic                  w_ss_fall;
  logic                  w_ss_rise;
  logic                  w_sclk_rise;
  logic                  w_sclk_fall;
  logic                  w_mosi;
  logic                  w_start;
  logic                  w_byte_done;
  logic                  w_load;
  logic [DATABITS-1:0]   w_tx_load;
  logic [DATABITS-1:0]   w_rx_byte;
  logic                  w_wr;
  logic                  w_rd_rx;
  logic                  w_tx_wr;
  logic                  w_tx_ok;
  logic                  w_st_wr;
  logic                  w_ctl_wr;
  logic                  w_trdy;
  logic                  w_tmt;
  logic                  w_e;
  logic [15:0]           w_status;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ss_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-1:0], SS_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-1:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign w_ss_fall   = ~r_ss_sync[SYNC_STAGES-1] &  r_ss_sync[SYNC_STAGES];
  assign w_ss_rise   =  r_ss_sync[SYNC_STAGES-1] & ~r_ss_sync[SYNC_STAGES];
  assign w_sclk_rise =  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES];
  assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] &  r_sclk_sync[SYNC_STAGES];
  assign w_mosi      =  r_mosi_sync[SYNC_STAGES-1];

  assign w_start     = (r_state == S_IDLE) & w_ss_fall;
  assign w_byte_done = (r_state == S_SHIFT) & ~w_ss_rise & w_sclk_rise &
                       (r_bitcnt == CW'(DATABITS - 1));
  assign w_load      = w_start | w_byte_done;
  // An unprimed holding register underruns: the slave sends zeros
  assign w_tx_load   = r_primed ? r_tx_hold : '0;
  assign w_rx_byte   = {r_rx_shift[DATABITS-2:0], w_mosi};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_bitcnt      <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_tx_pend     <= '0;
      r_reload_pend <= 1'b0;
      r_rx_hold     <= '0;
      r_miso_oe     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_miso_oe <= 1'b0;
          if (w_ss_fall) begin
            r_tx_shift    <= w_tx_load;
            r_bitcnt      <= '0;
            r_reload_pend <= 1'b0;
            r_miso_oe     <= 1'b1;
            r_state       <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_ss_rise) begin
            r_state       <= S_IDLE;
            r_bitcnt      <= '0;
            r_reload_pend <= 1'b0;
            r_miso_oe     <= 1'b0;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= w_rx_byte;
              if (r_bitcnt == CW'(DATABITS - 1)) begin
                r_bitcnt      <= '0;
                r_rx_hold     <= w_rx_byte;
                r_tx_pend     <= w_tx_load;
                r_reload_pend <= 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
            // Last bit must stay on MISO until SCLK falls, so the next byte lands then
            if (w_sclk_fall) begin
              if (r_reload_pend) begin
                r_tx_shift    <= r_tx_pend;
                r_reload_pend <= 1'b0;
              end else begin
                r_tx_shift <= {r_tx_shift[DATABITS-2:0], 1'b0};
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_wr     = spi_select & ~write_n;
  assign w_rd_rx  = spi_select & ~read_n & (mem_addr == 3'd0);
  assign w_tx_wr  = w_wr & (mem_addr == 3'd1);
  // A reload in the same cycle frees the holding register for the new write
  assign w_tx_ok  = w_tx_wr & (~r_primed | w_load);
  assign w_st_wr  = w_wr & (mem_addr == 3'd2);
  assign w_ctl_wr = w_wr & (mem_addr == 3'd3);
  assign w_trdy   = ~r_primed;
  assign w_tmt    = ~r_primed & (r_state == S_IDLE);
  assign w_e      = r_roe | r_toe | r_und;
  assign w_status = {6'b0, r_und, w_e, r_rrdy, w_trdy, w_tmt, r_toe, r_roe, 3'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_hold     <= '0;
      r_primed      <= 1'b0;
      r_rrdy        <= 1'b0;
      r_roe         <= 1'b0;
      r_toe         <= 1'b0;
      r_und         <= 1'b0;
      r_ctrl        <= '0;
      r_data_to_cpu <= '0;
      r_irq         <= 1'b0;
    end else begin
      if (w_tx_ok) begin
        r_tx_hold <= data_from_cpu[DATABITS-1:0];
        r_primed  <= 1'b1;
      end else if (w_load & r_primed) begin
        r_primed <= 1'b0;
      end

      if (w_load & ~r_primed)    r_und <= 1'b1;
      else if (w_st_wr)          r_und <= 1'b0;

      if (w_tx_wr & ~w_tx_ok)    r_toe <= 1'b1;
      else if (w_st_wr)          r_toe <= 1'b0;

      if (w_byte_done & r_rrdy)  r_roe <= 1'b1;
      else if (w_st_wr)          r_roe <= 1'b0;

      if (w_byte_done)           r_rrdy <= 1'b1;
      else if (w_rd_rx)          r_rrdy <= 1'b0;

      if (w_ctl_wr)              r_ctrl <= data_from_cpu & CTRL_MASK;

      case (mem_addr)
        3'd0:    r_data_to_cpu <= {{(16-DATABITS){1'b0}}, r_rx_hold};
        3'd2:    r_data_to_cpu <= w_status;
        3'd3:    r_data_to_cpu <= r_ctrl;
        default: r_data_to_cpu <= '0;
      endcase

      // Enable bits sit at the same positions as their status flags
      r_irq <= |(w_status & r_ctrl);
    end
  end

  assign MISO        = r_miso_oe & r_tx_shift[DATABITS-1];
  assign MISO_oe     = r_miso_oe;
  assign data_to_cpu = r_data_to_cpu;
  assign irq         = r_irq;

endmodule

// File: tb/tb_mi_nios_spi_slave.sv
// Directed plus randomized bench for mi_nios_spi_slave, checked against a
// byte-level model of the register/flag rules.
module tb_mi_nios_spi_slave;

  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        SCLK;
  logic        SS_n;
  logic        MOSI;
  logic        MISO;
  logic        MISO_oe;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_primed;
  logic [7:0]  m_hold;
  logic [7:0]  m_rx;
  bit          m_rrdy, m_roe, m_toe, m_und;
  logic [15:0] m_ctrl;

  always #6 clk = ~clk;

  mi_nios_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select),
    .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .irq(irq)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_primed = 0; m_hold = 0; m_rx = 0;
    m_rrdy = 0; m_roe = 0; m_toe = 0; m_und = 0; m_ctrl = 0;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0;
    s[3] = m_roe;
    s[4] = m_toe;
    s[5] = !m_primed;
    s[6] = !m_primed;
    s[7] = m_rrdy;
    s[8] = m_roe | m_toe | m_und;
    s[9] = m_und;
    return s;
  endfunction

  function automatic logic m_irq();
    return (m_roe & m_ctrl[3]) | (m_toe & m_ctrl[4]) | (!m_primed & m_ctrl[6]) |
           (m_rrdy & m_ctrl[7]) | ((m_roe | m_toe | m_und) & m_ctrl[8]);
  endfunction

  task automatic m_take(output logic [7:0] b);
    if (m_primed) begin
      b = m_hold;
      m_primed = 0;
    end else begin
      b = 8'h00;
      m_und = 1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
    case (a)
      3'd1: if (!m_primed) begin m_primed = 1; m_hold = d[7:0]; end
            else m_toe = 1;
      3'd2: begin m_roe = 0; m_toe = 0; m_und = 0; end
      3'd3: m_ctrl = d & 16'h01D8;
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
    @(negedge clk);
    d = data_to_cpu;
    spi_select = 1'b0; read_n = 1'b1; mem_addr = 3'd0;
    if (a == 3'd0) m_rrdy = 0;
  endtask

  task automatic check_status(input string tag);
    logic [15:0] d;
    repeat (4) @(negedge clk);
    check({tag, "_irq"}, {15'b0, irq}, {15'b0, m_irq()});
    bus_read(3'd2, d);
    check({tag, "_status"}, d, m_status());
  endtask

  task automatic check_rx(input string tag);
    logic [15:0] d;
    logic [7:0]  exp;
    exp = m_rx;
    bus_read(3'd0, d);
    check({tag, "_rxdata"}, d, {8'h00, exp});
  endtask

  // Master side of one frame; nbits < 8 aborts the frame early
  task automatic do_frame(input string tag, input logic [7:0] mo, input int nbits);
    logic [7:0] exp_mi, got, b;
    int oe_cnt;
    m_take(exp_mi);
    exp_mi = exp_mi & (8'hFF << (8 - nbits));
    got = 8'h00;
    oe_cnt = 0;
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[7-i];
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      got[7-i] = MISO;
      oe_cnt += int'(MISO_oe);
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
    if (nbits == 8) begin
      if (m_rrdy) m_roe = 1;
      m_rrdy = 1;
      m_rx = mo;
      m_take(b);
    end
    check({tag, "_miso"}, {8'h00, got}, {8'h00, exp_mi});
    check({tag, "_oe"}, 16'(oe_cnt), 16'(nbits));
  endtask

  initial begin
    logic [7:0] scratch;
    int nb;

    reset = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
    mem_addr = 3'd0; data_from_cpu = 16'h0;
    m_reset();
    repeat (5) @(negedge clk);
    check("rst_miso", {15'b0, MISO}, 16'h0);
    check("rst_oe", {15'b0, MISO_oe}, 16'h0);
    check("rst_dout", data_to_cpu, 16'h0);
    check("rst_irq", {15'b0, irq}, 16'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_status("post_rst");
    check_rx("post_rst");

    // Primed TX byte, 1 MHz frame
    bus_write(3'd1, 16'h00A5);
    do_frame("t1", 8'h3C, 8);
    check_status("t1");
    check_rx("t1");

    // Overrun, then status write clears ROE but not RRDY
    do_frame("t2a", 8'h11, 8);
    do_frame("t2b", 8'h22, 8);
    check_status("t2_ovr");
    bus_write(3'd2, 16'h0000);
    check_status("t2_clr");
    check_rx("t2");

    // Underrun with iE enabled
    bus_write(3'd2, 16'h0000);
    bus_write(3'd3, 16'h0100);
    do_frame("t3", 8'hC3, 8);
    check_status("t3");
    check_rx("t3");

    // Second TX write while not ready
    bus_write(3'd2, 16'h0000);
    bus_write(3'd1, 16'h0055);
    bus_write(3'd1, 16'h0066);
    check_status("t4_toe");
    do_frame("t4", 8'h96, 8);
    check_status("t4");
    check_rx("t4");

    // Aborted partial frame, then a full frame
    bus_write(3'd2, 16'h0000);
    do_frame("t5p", 8'hF0, 4);
    check_status("t5_part");
    bus_write(3'd1, 16'h003E);
    do_frame("t5", 8'h81, 8);
    check_status("t5");
    check_rx("t5");

    // Reset in the middle of bit 5
    bus_write(3'd3, 16'h0040);
    bus_write(3'd1, 16'h0077);
    m_take(scratch);
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    check("t6_pre_irq", {15'b0, irq}, {15'b0, m_irq()});
    check("t6_pre_oe", {15'b0, MISO_oe}, 16'h1);
    reset = 1'b1;
    #1;
    check("t6_oe", {15'b0, MISO_oe}, 16'h0);
    check("t6_irq", {15'b0, irq}, 16'h0);
    check("t6_dout", data_to_cpu, 16'h0);
    SS_n = 1'b1;
    repeat (4) @(negedge clk);
    m_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_status("t6_post");
    bus_write(3'd1, 16'h005A);
    do_frame("t6", 8'hA7, 8);
    check_status("t6_frame");
    check_rx("t6");

    // Randomized traffic
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) bus_write(3'd3, 16'($urandom));
      nb = int'($urandom_range(0, 2));
      for (int w = 0; w < nb; w++) bus_write(3'd1, 16'($urandom));
      if ($urandom_range(0, 4) == 0) nb = int'($urandom_range(1, 7));
      else nb = 8;
      do_frame("rnd", 8'($urandom), nb);
      check_status("rnd");
      if ($urandom_range(0, 1) == 1) bus_write(3'd2, 16'h0000);
      if ($urandom_range(0, 1) == 1) check_rx("rnd");
    end
    check_status("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mi_nios_spi_slave.md
Name: mi_nios_spi_slave

Overview:
- SPI slave (responder) endpoint, register-mapped on the Nios Avalon bus.
- Serves an external SPI master, e.g. the touch controller side or a host MCU.
- Fixed mode: CPOL=0, CPHA=0, MSB first, 8-bit frames.
- All SPI pins are oversampled in the clk domain (no SCLK clocking); RX/TX single-byte holding registers with status flags and IRQ.

Parameters:
DATABITS, 8, frame width in bits (bench and RTL fixed at 8)
SYNC_STAGES, 2, flip-flop stages on SCLK/SS_n/MOSI synchronizers

Ports:
clk  input  1  system clock (80 MHz)
reset  input  1  asynchronous reset, active-high
SCLK  input  1  SPI clock from master
SS_n  input  1  slave select, active low
MOSI  input  1  master-out data
MISO  output  1  slave-out data
MISO_oe  output  1  MISO tristate enable, high while selected
spi_select  input  1  Avalon chipselect
mem_addr  input  3  register address
read_n  input  1  read strobe, active low
write_n  input  1  write strobe, active low
data_from_cpu  input  16  write data
data_to_cpu  output  16  read data, registered
irq  output  1  interrupt, registered

Behaviour:
- Reset values:
  - outputs: MISO=0, MISO_oe=0, data_to_cpu=0, irq=0.
  - internal: all flags 0, bit counter 0, shift/holding registers 0, state IDLE.
- Register map:
  - 0 rxdata (r)
  - 1 txdata (w)
  - 2 status (r; any write clears ROE, TOE, UND)
  - 3 control (r/w irq enables)
- Status bits: [3] ROE, [4] TOE, [5] TMT, [6] TRDY, [7] RRDY, [8] E=ROE|TOE|UND, [9] UND. All other bits read 0.
- Control bits: [3] iROE, [4] iTOE, [6] iTRDY, [7] iRRDY, [8] iE.
- Bus timing:
  - A write takes effect on the clk edge where spi_select & ~write_n.
  - data_to_cpu is updated on every edge from mem_addr (read latency 1).
  - RRDY clears on the edge after a cycle with spi_select & ~read_n & mem_addr==0.
- Pin synchronization:
  - SCLK, SS_n and MOSI pass through SYNC_STAGES flops.
  - Edges are detected from the last two synchronized samples.
  - Supported SCLK is at most clk/8 (10 MHz).
- State machine:
  - IDLE: MISO_oe=0.
    - On synchronized SS_n falling edge: load tx_shift from tx_holding if primed (clear primed), else load 0x00 and set UND.
    - Clear bit counter, go to SHIFT.
  - SHIFT: MISO_oe=1, MISO=tx_shift[7].
    - Synchronized SCLK rising edge: rx_shift <= {rx_shift[6:0], MOSI_sync}; bitcnt+1.
    - Synchronized SCLK falling edge: tx_shift <= {tx_shift[6:0], 0}, unless a byte completed on the preceding rising edge.
    - On the 8th rising edge:
      - rx_holding <= assembled byte; RRDY <= 1; if RRDY was already 1, ROE <= 1 and rx_holding is still overwritten.
      - bitcnt <= 0.
      - Reload tx_shift from tx_holding (same rule as IDLE), effective on the next SCLK falling edge.
  - SHIFT exit: synchronized SS_n rising edge → IDLE in any bit position.
    - A partial byte is discarded: RRDY/rx_holding unchanged, bitcnt cleared.
- TRDY = ~tx_holding_primed.
  - A txdata write with TRDY=1 loads tx_holding[7:0] and sets primed.
  - A txdata write with TRDY=0 sets TOE and is dropped.
- TMT = ~primed & (state==IDLE).
- Simultaneous events:
  - txdata write in the same cycle as a reload: the reload takes the old holding value; the new value is primed.
  - Status write in the same cycle as an ROE set: the set wins.
- irq registered: (ROE&iROE)|(TOE&iTOE)|(TRDY&iTRDY)|(RRDY&iRRDY)|(E&iE).
- Reset mid-frame: immediate return to IDLE, MISO_oe=0, and all reset values apply.

Test Plan:
- Write txdata=0xA5, master sends 0x3C at 1 MHz → MISO bits 1,0,1,0,0,1,0,1; rxdata=0x3C; RRDY=1; TMT=1 after SS_n rises.
- Two frames 0x11, 0x22 with no rxdata read between them → ROE=1, rxdata=0x22; status write clears ROE, RRDY stays 1.
- No txdata write before a frame → MISO all zeros, UND=1, E=1; irq=1 when iE=1.
- Two txdata writes (0x55 then 0x66) before any frame → second write sets TOE=1, frame transmits 0x55.
- SS_n deasserted after 4 SCLK rising edges → RRDY=0, rxdata unchanged; next full frame 0x81 received correctly as 0x81.
- Assert reset during bit 5 of a frame → MISO_oe=0, irq=0, data_to_cpu=0; next frame after reset receives correctly.
